// File: rtl/renkon_layer_sched.sv
// Layer sequencer for the renkon conv engine.
// Walks the host-written descriptor table, one req/ack handshake per layer.
module renkon_layer_sched #(
   parameter  int N_LAYER = 8,
   parameter  int LWIDTH  = 16,
   parameter  int NFIELD  = 16,
   localparam int LW      = $clog2(N_LAYER),
   localparam int NW      = $clog2(N_LAYER + 1),
   localparam int FW      = $clog2(NFIELD)
) (
   input  logic                     clk,
   input  logic                     xrst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [NW-1:0]            num_layer,
   input  logic                     cfg_we,
   input  logic [LW-1:0]            cfg_layer,
   input  logic [FW-1:0]            cfg_field,
   input  logic [LWIDTH-1:0]        cfg_wdata,
   input  logic                     ack,
   output logic                     req,
   output logic [NFIELD*LWIDTH-1:0] prm,
   output logic [LW-1:0]            cur_layer,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state;
   logic [NW-1:0]     nl;
   logic [NW-1:0]     nl_in;
   logic              last;
   logic [LWIDTH-1:0] tbl [N_LAYER][NFIELD];

   assign nl_in = (num_layer > NW'(N_LAYER)) ? NW'(N_LAYER) : num_layer;
   assign last  = (NW'(cur_layer) == nl - NW'(1));
   assign busy  = (state != S_IDLE);

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state     <= S_IDLE;
         nl        <= '0;
         cur_layer <= '0;
         prm       <= '0;
         req       <= 1'b0;
         done      <= 1'b0;
         for (int i = 0; i < N_LAYER; i++)
            for (int j = 0; j < NFIELD; j++)
               tbl[i][j] <= '0;
      end else begin
         if (cfg_we)
            tbl[cfg_layer][cfg_field] <= cfg_wdata;
         if (abort && state != S_IDLE) begin
            state <= S_IDLE;
            req   <= 1'b0;
            done  <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start) begin
                     if (nl_in != '0) begin
                        cur_layer <= '0;
                        nl        <= nl_in;
                        state     <= S_LOAD;
                     end else begin
                        state <= S_DONE;
                     end
                  end
               end
               S_LOAD: begin
                  for (int f = 0; f < NFIELD; f++)
                     prm[f*LWIDTH +: LWIDTH] <= tbl[cur_layer][f];
                  req   <= 1'b1;
                  state <= S_REQ;
               end
               S_REQ: begin
                  req   <= 1'b0;
                  state <= S_WAIT;
               end
               S_WAIT: begin
                  if (ack) begin
                     if (last) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                     end else begin
                        cur_layer <= cur_layer + LW'(1);
                        state     <= S_LOAD;
                     end
                  end
               end
               // zero-layer runs arrive with done low and spend one extra cycle here
               S_DONE: begin
                  if (done) begin
                     done  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     done <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_renkon_layer_sched.sv
// Directed bench for renkon_layer_sched.
// Hand-computed expectations for sequencing, clamping, abort and reset.
module tb_renkon_layer_sched;

   logic         clk = 1'b0;
   logic         xrst;
   logic         start;
   logic         abort;
   logic [3:0]   num_layer;
   logic         cfg_we;
   logic [2:0]   cfg_layer;
   logic [3:0]   cfg_field;
   logic [15:0]  cfg_wdata;
   logic         ack;
   logic         req;
   logic [255:0] prm;
   logic [2:0]   cur_layer;
   logic         busy;
   logic         done;

   int n_chk  = 0;
   int n_fail = 0;

   renkon_layer_sched dut (
      .clk       (clk),
      .xrst      (xrst),
      .start     (start),
      .abort     (abort),
      .num_layer (num_layer),
      .cfg_we    (cfg_we),
      .cfg_layer (cfg_layer),
      .cfg_field (cfg_field),
      .cfg_wdata (cfg_wdata),
      .ack       (ack),
      .req       (req),
      .prm       (prm),
      .cur_layer (cur_layer),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int l, input int f, input int d);
      cfg_we    = 1'b1;
      cfg_layer = 3'(l);
      cfg_field = 4'(f);
      cfg_wdata = 16'(d);
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   function automatic logic [15:0] fld(input int f);
      return prm[f*16 +: 16];
   endfunction

   initial begin
      int stray;
      int nreq;
      int gotdone;
      xrst      = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      num_layer = '0;
      cfg_we    = 1'b0;
      cfg_layer = '0;
      cfg_field = '0;
      cfg_wdata = '0;
      ack       = 1'b0;
      repeat (2) tick();
      check("rst_req", 32'(req), 0);
      check("rst_done", 32'(done), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_cur", 32'(cur_layer), 0);
      check("rst_prm", 32'(|prm), 0);
      xrst = 1'b1;
      tick();

      // 1) two layers, ack 10 cycles after each req
      wr(0, 9, 3);
      wr(1, 9, 5);
      num_layer = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_load_busy", 32'(busy), 1);
      check("t1_load_req", 32'(req), 0);
      tick();
      check("t1_req0", 32'(req), 1);
      check("t1_prm0", 32'(fld(9)), 3);
      check("t1_cur0", 32'(cur_layer), 0);
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (req || !busy) stray++;
      end
      check("t1_wait0", stray, 0);
      pulse_ack();
      check("t1_a1_req", 32'(req), 0);
      tick();
      check("t1_req1", 32'(req), 1);
      check("t1_prm1", 32'(fld(9)), 5);
      check("t1_cur1", 32'(cur_layer), 1);
      repeat (10) tick();
      pulse_ack();
      check("t1_done", 32'(done), 1);
      check("t1_done_busy", 32'(busy), 1);
      tick();
      check("t1_done_end", 32'(done), 0);
      check("t1_idle", 32'(busy), 0);
      check("t1_hold_prm", 32'(fld(9)), 5);
      check("t1_hold_cur", 32'(cur_layer), 1);

      // 2) zero layers
      num_layer = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t2_busy1", 32'(busy), 1);
      check("t2_done1", 32'(done), 0);
      check("t2_req1", 32'(req), 0);
      tick();
      check("t2_busy2", 32'(busy), 1);
      check("t2_done2", 32'(done), 1);
      check("t2_req2", 32'(req), 0);
      tick();
      check("t2_busy3", 32'(busy), 0);
      check("t2_done3", 32'(done), 0);

      // 3) num_layer clamped to 8
      num_layer = 4'd12;
      start = 1'b1;
      tick();
      start = 1'b0;
      nreq = 0;
      gotdone = 0;
      for (int c = 0; c < 200 && gotdone == 0; c++) begin
         if (req) begin
            check("t3_layer", 32'(cur_layer), nreq);
            nreq++;
            tick();
            tick();
            pulse_ack();
         end else if (done) begin
            gotdone = 1;
         end else begin
            tick();
         end
      end
      check("t3_reqs", nreq, 8);
      check("t3_done", gotdone, 1);
      tick();
      check("t3_idle", 32'(busy), 0);

      // 4) table write during WAIT; ack in REQ cycle ignored
      num_layer = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("t4_req", 32'(req), 1);
      check("t4_prm_a", 32'(fld(9)), 3);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      wr(0, 9, 7);
      check("t4_ack_in_req", 32'(done), 0);
      check("t4_still_busy", 32'(busy), 1);
      check("t4_prm_b", 32'(fld(9)), 3);
      pulse_ack();
      check("t4_done", 32'(done), 1);
      check("t4_prm_c", 32'(fld(9)), 3);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("t4_rerun_req", 32'(req), 1);
      check("t4_rerun_prm", 32'(fld(9)), 7);
      tick();
      pulse_ack();
      tick();

      // 5) abort in WAIT of layer 1 of 3
      num_layer = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      pulse_ack();
      tick();
      check("t5_req1", 32'(req), 1);
      check("t5_cur1", 32'(cur_layer), 1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5_abort_busy", 32'(busy), 0);
      check("t5_abort_done", 32'(done), 0);
      check("t5_abort_req", 32'(req), 0);
      pulse_ack();
      tick();
      check("t5_late_ack_busy", 32'(busy), 0);
      check("t5_late_ack_done", 32'(done), 0);
      num_layer = 4'd1;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("t5_restart_busy", 32'(busy), 1);
      tick();
      check("t5_restart_req", 32'(req), 1);
      check("t5_restart_cur", 32'(cur_layer), 0);
      tick();
      pulse_ack();
      check("t5_restart_done", 32'(done), 1);
      tick();

      // 6) async reset during REQ
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("t6_pre_req", 32'(req), 1);
      xrst = 1'b0;
      #1;
      check("t6_rst_req", 32'(req), 0);
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_prm", 32'(|prm), 0);
      #1;
      xrst = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("t6_run_req", 32'(req), 1);
      check("t6_tbl_zero", 32'(|prm), 0);
      tick();
      pulse_ack();
      check("t6_done", 32'(done), 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
